// File: rtl/timer_bank_pkg.sv
// Shared register map and CTRL bit layout for the timer bank.
package timer_bank_pkg;

  localparam int unsigned CH_STRIDE = 16;
  localparam int unsigned CTRL_W    = 3;

  localparam logic [3:0] TH_OFF   = 4'h0;
  localparam logic [3:0] TL_OFF   = 4'h4;
  localparam logic [3:0] CTRL_OFF = 4'h8;

  localparam logic [7:0] PEND_OFF  = 8'h80;
  localparam logic [7:0] GIE_OFF   = 8'h84;
  localparam logic [7:0] PRESC_OFF = 8'h88;

  localparam int unsigned EN_B = 0;
  localparam int unsigned IE_B = 1;
  localparam int unsigned OS_B = 2;

endpackage

// File: rtl/timer_channel.sv
// One up-counting timer: reload (TH), live count (TL), CTRL, and a combinational overflow strobe.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_i,
  input  logic              th_we_i,
  input  logic              tl_we_i,
  input  logic              ctrl_we_i,
  input  logic [CNT_W-1:0]  wdata_i,
  output logic [CNT_W-1:0]  th_o,
  output logic [CNT_W-1:0]  tl_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              ovf_o
);

  logic [CNT_W-1:0]  th_q, th_d, tl_q, tl_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              run;

  always_comb begin
    // A CTRL write that clears EN freezes the counter on that very edge.
    run    = ctrl_q[EN_B] & tick_i & ~(ctrl_we_i & ~wdata_i[EN_B]);
    ovf_o  = run & (&tl_q);
    th_d   = th_we_i ? wdata_i : th_q;
    tl_d   = tl_q;
    ctrl_d = ctrl_q;
    if (run) begin
      tl_d = ovf_o ? th_q : tl_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (ovf_o && ctrl_q[OS_B]) begin
      ctrl_d[EN_B] = 1'b0;
    end
    if (tl_we_i) begin
      tl_d = wdata_i;
    end
    if (ctrl_we_i) begin
      ctrl_d = wdata_i[CTRL_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      ctrl_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped bank of N_CH timers with W1C pending flags and a global interrupt enable.
// Define TIMER_BANK_PRESCALE_EN to add the shared PRESC count-enable prescaler at +0x88.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h40000100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irqout,
  output logic [N_CH-1:0] ch_tick
);

  logic [31:0]       off;
  logic [3:0]        reg_off;
  logic              in_ch;
  logic [N_CH-1:0]   ch_sel, th_we, tl_we, ctrl_we, ovf_v, ie_v;
  logic [N_CH-1:0]   pend_q, pend_d, tick_q;
  logic              gie_q, gie_d;
  logic              tick;
  logic [CNT_W-1:0]  th_v [N_CH];
  logic [CNT_W-1:0]  tl_v [N_CH];
  logic [CTRL_W-1:0] ctrl_v [N_CH];

  assign off     = addr - BASE_ADDR;
  assign reg_off = off[3:0];
  assign in_ch   = off < 32'(CH_STRIDE * N_CH);

  always_comb begin
    ch_sel = '0;
    th_we  = '0;
    tl_we  = '0;
    ctrl_we = '0;
    ie_v   = '0;
    for (int c = 0; c < N_CH; c++) begin
      ch_sel[c]  = in_ch && (off[6:4] == 3'(c));
      th_we[c]   = wr && ch_sel[c] && (reg_off == TH_OFF);
      tl_we[c]   = wr && ch_sel[c] && (reg_off == TL_OFF);
      ctrl_we[c] = wr && ch_sel[c] && (reg_off == CTRL_OFF);
      ie_v[c]    = ctrl_v[c][IE_B];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick_i   (tick),
      .th_we_i  (th_we[g]),
      .tl_we_i  (tl_we[g]),
      .ctrl_we_i(ctrl_we[g]),
      .wdata_i  (wdata[CNT_W-1:0]),
      .th_o     (th_v[g]),
      .tl_o     (tl_v[g]),
      .ctrl_o   (ctrl_v[g]),
      .ovf_o    (ovf_v[g])
    );
  end

`ifdef TIMER_BANK_PRESCALE_EN
  logic [15:0] presc_q, presc_d, pcnt_q, pcnt_d;

  always_comb begin
    tick    = (pcnt_q == presc_q);
    presc_d = presc_q;
    pcnt_d  = tick ? 16'd0 : pcnt_q + 16'd1;
    if (wr && (off == 32'(PRESC_OFF))) begin
      presc_d = wdata[15:0];
      pcnt_d  = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    gie_d  = gie_q;
    pend_d = pend_q;
    if (wr && (off == 32'(PEND_OFF))) begin
      pend_d = pend_q & ~wdata[N_CH-1:0];
    end
    if (wr && (off == 32'(GIE_OFF))) begin
      gie_d = wdata[0];
    end
    // Overflow is applied after the W1C so that a set on the same edge wins.
    pend_d = pend_d | ovf_v;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      gie_q  <= 1'b0;
      tick_q <= '0;
    end else begin
      pend_q <= pend_d;
      gie_q  <= gie_d;
      tick_q <= ovf_v;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_sel[c]) begin
          case (reg_off)
            TH_OFF:   rdata = 32'(th_v[c]);
            TL_OFF:   rdata = 32'(tl_v[c]);
            CTRL_OFF: rdata = 32'(ctrl_v[c]);
            default:  rdata = '0;
          endcase
        end
      end
      if (off == 32'(PEND_OFF)) rdata = 32'(pend_q);
      if (off == 32'(GIE_OFF))  rdata = {31'd0, gie_q};
`ifdef TIMER_BANK_PRESCALE_EN
      if (off == 32'(PRESC_OFF)) rdata = {16'd0, presc_q};
`endif
    end
  end

  assign irqout  = gie_q & |(pend_q & ie_v);
  assign ch_tick = tick_q;

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: stimulus queues expected values, a negedge monitor checks them.
module tb_timer_bank;

  localparam logic [31:0] BASE  = 32'h40000100;
  localparam logic [31:0] PEND  = BASE + 32'h80;
  localparam logic [31:0] GIE   = BASE + 32'h84;
  localparam logic [31:0] PRESC = BASE + 32'h88;

  localparam int K_RDATA = 0;
  localparam int K_IRQ   = 1;
  localparam int K_TICK  = 2;

  logic        clk = 1'b0;
  logic        reset, rd, wr, chk_req;
  logic [31:0] addr, wdata, rdata;
  logic        irqout;
  logic [3:0]  ch_tick;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] act;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  timer_bank #(
    .N_CH     (4),
    .CNT_W    (32),
    .BASE_ADDR(BASE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irqout (irqout),
    .ch_tick(ch_tick)
  );

  always @(negedge clk) begin
    if (rd || chk_req) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: DUT output sampled with no expected value queued");
      end else begin
        cur = sb.pop_front();
        case (cur.kind)
          K_RDATA: act = rdata;
          K_IRQ:   act = {31'd0, irqout};
          default: act = {28'd0, ch_tick};
        endcase
        if (act !== cur.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
        end
      end
    end
  end

  function automatic logic [31:0] ch(input int c, input int o);
    return BASE + 32'(16 * c + o);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    step();
    wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a, input logic [31:0] e, input string nm);
    rd = 1'b1; addr = a;
    sb.push_back('{kind: K_RDATA, exp: e, name: nm});
    step();
    rd = 1'b0;
  endtask

  task automatic chk(input int k, input logic [31:0] e, input string nm);
    chk_req = 1'b1;
    sb.push_back('{kind: k, exp: e, name: nm});
    step();
    chk_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; rd = 1'b0; wr = 1'b0; chk_req = 1'b0; addr = '0; wdata = '0;
    #12 reset = 1'b1;
    step();

    // Reset state of every mapped register
    for (int c = 0; c < 4; c++) begin
      for (int o = 0; o < 12; o += 4) rd_reg(ch(c, o), 32'h0, "reset_reg");
    end
    rd_reg(PEND, 32'h0, "reset_pend");
    rd_reg(GIE, 32'h0, "reset_gie");
    rd_reg(PRESC, 32'h0, "reset_presc");
    chk(K_IRQ, 32'h0, "reset_irq");
    chk(K_TICK, 32'h0, "reset_tick");

    // Ch0 auto-reload
    wr_reg(ch(0, 0), 32'hFFFFFFFC);
    wr_reg(ch(0, 4), 32'hFFFFFFFC);
    wr_reg(GIE, 32'h1);
    addr = ch(0, 0);
    chk(K_RDATA, 32'h0, "rd_low_zero");
    wr_reg(ch(0, 8), 32'h3);
    rd_reg(ch(0, 4), 32'hFFFFFFFC, "t2_tl_start");
    rd_reg(PEND, 32'h0, "t2_pend_early");
    chk(K_IRQ, 32'h0, "t2_irq_early");
    rd_reg(ch(0, 4), 32'hFFFFFFFF, "t2_tl_max");
    rd_reg(PEND, 32'h1, "t2_pend_set");
    rd_reg(ch(0, 4), 32'hFFFFFFFD, "t2_reload");
    chk(K_IRQ, 32'h1, "t2_irq_high");
    wr_reg(ch(0, 8), 32'h0);
    rd_reg(ch(0, 4), 32'hFFFFFFFF, "t2_en_stop_hold");
    wr_reg(PEND, 32'h1);
    chk(K_IRQ, 32'h0, "t2_irq_cleared");
    rd_reg(PEND, 32'h0, "t2_pend_cleared");

    // Ch1 one-shot
    wr_reg(ch(1, 0), 32'h0);
    wr_reg(ch(1, 4), 32'hFFFFFFFE);
    wr_reg(ch(1, 8), 32'h7);
    rd_reg(ch(1, 4), 32'hFFFFFFFE, "t3_tl_start");
    rd_reg(ch(1, 8), 32'h7, "t3_ctrl_running");
    rd_reg(PEND, 32'h2, "t3_pend");
    rd_reg(ch(1, 8), 32'h6, "t3_ctrl_en_cleared");
    chk(K_IRQ, 32'h1, "t3_irq");
    repeat (10) step();
    rd_reg(ch(1, 4), 32'h0, "t3_tl_stopped");
    wr_reg(PEND, 32'h2);
    chk(K_IRQ, 32'h0, "t3_irq_cleared");

    // Ch2 collisions on the overflow edge
    wr_reg(ch(2, 0), 32'h0);
    wr_reg(ch(2, 4), 32'hFFFFFFFF);
    wr_reg(ch(2, 8), 32'h1);
    wr_reg(PEND, 32'h4);
    rd_reg(PEND, 32'h4, "t4_set_beats_clear");
    wr_reg(ch(2, 8), 32'h0);
    wr_reg(PEND, 32'h4);
    rd_reg(PEND, 32'h0, "t4_pend_w1c");
    wr_reg(ch(2, 4), 32'hFFFFFFFF);
    wr_reg(ch(2, 8), 32'h1);
    wr_reg(ch(2, 4), 32'h5);
    rd_reg(ch(2, 4), 32'h5, "t4_tl_write_wins");
    rd_reg(PEND, 32'h4, "t4_pend_on_tl_write");
    wr_reg(ch(2, 8), 32'h0);
    wr_reg(PEND, 32'h4);

    // Ch3 masking
    wr_reg(ch(3, 0), 32'h0);
    wr_reg(ch(3, 4), 32'hFFFFFFFF);
    wr_reg(ch(3, 8), 32'h1);
    step();
    chk(K_TICK, 32'h8, "t5_ch_tick");
    chk(K_TICK, 32'h0, "t5_tick_one_cycle");
    rd_reg(PEND, 32'h8, "t5_pend_ie0");
    chk(K_IRQ, 32'h0, "t5_irq_ie0");
    wr_reg(GIE, 32'h0);
    wr_reg(ch(3, 8), 32'h3);
    chk(K_IRQ, 32'h0, "t5_irq_gie0");
    rd_reg(PEND, 32'h8, "t5_pend_gie0");
    wr_reg(GIE, 32'h1);
    chk(K_IRQ, 32'h1, "t5_irq_unmasked");

    // Unmapped addresses
    wr_reg(ch(4, 0), 32'h1234);
    rd_reg(ch(4, 0), 32'h0, "unmapped_ch4");
    rd_reg(ch(0, 12), 32'h0, "unmapped_off_c");

`ifdef TIMER_BANK_PRESCALE_EN
    wr_reg(PRESC, 32'h3);
    rd_reg(PRESC, 32'h3, "t6_presc_rw");
    wr_reg(ch(0, 0), 32'h0);
    wr_reg(ch(0, 4), 32'hFFFFFFFE);
    wr_reg(ch(0, 8), 32'h1);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ch_tick[0]) begin
        n = k;
        break;
      end
    end
    checks++;
    if (n < 5 || n > 9) begin
      errors++;
      $display("FAIL t6_presc_ovf: overflow after %0d cycles, expected 5..9", n);
    end
`else
    n = 0;
    wr_reg(PRESC, 32'h3);
    rd_reg(PRESC, 32'h0, "t6_presc_absent");
`endif

    // Asynchronous reset mid-count
    reset = 1'b0;
    #2 reset = 1'b1;
    rd_reg(PEND, 32'h0, "rst_pend");
    chk(K_IRQ, 32'h0, "rst_irq");
    rd_reg(ch(3, 8), 32'h0, "rst_ctrl3");
    rd_reg(ch(3, 4), 32'h0, "rst_tl3");
    rd_reg(GIE, 32'h0, "rst_gie");

    repeat (2) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected values left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
